simd_frame_writer: RTL and testbench
====================================

Name: simd_frame_writer

Overview:
- Sink end of the SIMD pixel stream produced by the threshold datapath.
- Accepts one beat of SIMD_WIDTH 8-bit pixels per handshake and writes it as one word into a frame buffer over a req/gnt memory port.
- Tracks row and column, checks end-of-line framing, and asserts done after a full HEIGHT x WIDTH frame. This `done` is the completion signal the image benches wait on.

Parameters:
- WIDTH, 64, pixels per row; must be a multiple of SIMD_WIDTH.
- HEIGHT, 64, rows per frame.
- SIMD_WIDTH, 4, pixels per beat; the memory word width is SIMD_WIDTH*8.
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; arms the writer for one frame.
- base_addr_i  in  ADDR_W  frame base byte address; sampled on an accepted start.
- s_valid_i  in  1  pixel beat valid.
- s_ready_o  out  1  pixel beat ready.
- s_data_i  in  SIMD_WIDTH*8  pixels; pixel k occupies bits [8k+7:8k] (lowest column in the LSB).
- s_eol_i  in  1  beat is the last of its row.
- mem_req_o  out  1  write request.
- mem_gnt_i  in  1  grant.
- mem_we_o  out  1  write enable; constant 1.
- mem_addr_o  out  ADDR_W  byte address.
- mem_wdata_o  out  SIMD_WIDTH*8  write data.
- mem_be_o  out  SIMD_WIDTH  byte enables; all ones.
- row_o  out  $clog2(HEIGHT)  current row.
- col_o  out  $clog2(WIDTH)  current column, in pixels.
- busy_o  out  1  frame in progress.
- done_o  out  1  frame complete; held high.
- err_o  out  1  sticky framing error.

Behaviour:
- Reset (async, rst_ni=0) sets all outputs to 0 and the FSM to IDLE: s_ready_o, mem_req_o, mem_addr_o, mem_wdata_o, row_o, col_o, busy_o, done_o and err_o are all 0. mem_we_o and mem_be_o are constants.
- FSM states:
  - IDLE -> RUN on start_i. This latches base_addr_i, clears row, col, beat counter, done_o and err_o, and sets busy_o.
  - RUN -> FLUSH when the final beat (beat index HEIGHT*WIDTH/SIMD_WIDTH-1) is accepted.
  - FLUSH -> DONE when the outstanding request is granted.
  - DONE -> RUN on start_i, with the same clears as from IDLE.
  - DONE holds done_o=1 and busy_o=0.
- start_i in RUN or FLUSH is ignored.
- Request register (one entry):
  - s_ready_o = (state==RUN) && (!mem_req_o || mem_gnt_i).
  - Accept = s_valid_i && s_ready_o. On accept, the next cycle has mem_req_o=1, mem_addr_o = base + beat_idx*SIMD_WIDTH and mem_wdata_o = s_data_i.
  - mem_req_o drops the cycle after a grant unless a new beat is accepted in that same cycle. Back-to-back beats at one beat per cycle are possible when gnt is tied high.
  - While mem_req_o && !mem_gnt_i, the address and data are held stable.
- Latency: an accepted beat appears on the memory port 1 cycle later.
- Counters: on accept, col advances by SIMD_WIDTH. At col==WIDTH-SIMD_WIDTH, col wraps to 0 and row increments.
- Address arithmetic is modulo 2^ADDR_W, so wrap-around at the top of the address space is silent.
- Framing: on accept, s_eol_i must equal (col==WIDTH-SIMD_WIDTH). On a mismatch err_o sets and stays set until the next start; the counters ignore s_eol_i.
- done_o rises the cycle after the final grant. Exactly HEIGHT*WIDTH/SIMD_WIDTH requests are granted per frame.
- Reset mid-frame aborts immediately: mem_req_o drops asynchronously with no completion, and the state returns to IDLE.
- A start_i and the final grant in the same cycle: the grant completes FLUSH -> DONE; start_i is ignored.

Decomposition:
- Shared package pkg_img holds the defaults and derived constants:
  - IMG_WIDTH=64, IMG_HEIGHT=64, SIMD_WIDTH=4, THRESHOLD=8'd128.
  - BEATS_PER_ROW = WIDTH/SIMD_WIDTH.
  - BEATS_PER_FRAME = HEIGHT*BEATS_PER_ROW.
  - The FSM enum typedef writer_state_e {IDLE, RUN, FLUSH, DONE}.
  - The typedef pix_beat_t = logic [SIMD_WIDTH*8-1:0].
- One natural sub-module, frame_addr_gen: row, col and beat counters plus the address computation, with increment, clear and last outputs.
- The FSM and request register stay in the top module.

Test Plan:
- Full frame with gnt tied high, s_valid continuous, base 0x1000, pixel beat n = {4{n[7:0]}} -> 1024 writes at addresses 0x1000, 0x1004 ... 0x1FFC in order. done_o rises 1 cycle after the last grant, in cycle start+1026. err_o=0.
- Random grant stalls (gnt 30% of cycles) and random s_valid -> addresses and data are stable during stalls, no beat is lost or duplicated, and the memory image matches the input.
- Framing error: s_eol_i asserted on beat 5 (col=20) of row 0 -> err_o=1 from the next cycle and held. The frame still completes with 1024 writes and done_o=1.
- Reset asserted during row 10 with mem_req_o=1 and gnt low -> mem_req_o, busy_o and s_ready_o are 0 immediately. After release the state is IDLE, and a new start writes the full frame from the new base.
- Restart from DONE with base 0x8000 -> done_o clears the cycle after start, the first address is 0x8000, and done_o is set again after 1024 grants. A start pulse during RUN has no effect.
- Thresholded checker pattern: input pixels 200/50 alternating, passed through the threshold at 128 -> written bytes alternate 0xFF/0x00. The word for beat 0 is 0x00FF00FF.

Source files
------------

// File: rtl/pkg_img.sv
// Shared image-pipeline constants and types: default frame geometry, threshold
// level, derived beat counts, the frame-writer FSM encoding and the pixel beat type.
package pkg_img;

    localparam int unsigned IMG_WIDTH       = 64;
    localparam int unsigned IMG_HEIGHT      = 64;
    localparam int unsigned SIMD_WIDTH      = 4;
    localparam logic [7:0]  THRESHOLD       = 8'd128;
    localparam int unsigned BEATS_PER_ROW   = IMG_WIDTH / SIMD_WIDTH;
    localparam int unsigned BEATS_PER_FRAME = IMG_HEIGHT * BEATS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } writer_state_e;

    typedef logic [SIMD_WIDTH*8-1:0] pix_beat_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Row/column/beat counters for the frame writer and the byte address of the
// beat currently being offered.
// Ports: clk, rst_ni; clr_i (load base_i, zero counters); inc_i (advance one
// beat); row_o/col_o registered position; addr_c, eol_c, last_c combinational
// address, end-of-row flag and final-beat flag for the current beat.
module frame_addr_gen #(
    parameter int unsigned WIDTH      = pkg_img::IMG_WIDTH,
    parameter int unsigned HEIGHT     = pkg_img::IMG_HEIGHT,
    parameter int unsigned SIMD_WIDTH = pkg_img::SIMD_WIDTH,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic [ADDR_W-1:0]         base_i,
    input  logic                      inc_i,
    output logic [$clog2(HEIGHT)-1:0] row_o,
    output logic [$clog2(WIDTH)-1:0]  col_o,
    output logic [ADDR_W-1:0]         addr_c,
    output logic                      eol_c,
    output logic                      last_c
);

    localparam int unsigned ROW_W  = $clog2(HEIGHT);
    localparam int unsigned COL_W  = $clog2(WIDTH);
    localparam int unsigned BEATS  = HEIGHT * (WIDTH / SIMD_WIDTH);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [ADDR_W-1:0] base_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [BEAT_W-1:0] beat_q;

    // Position of the beat being offered; address wraps silently modulo 2^ADDR_W.
    always_comb begin
        eol_c  = (col_q == COL_W'(WIDTH - SIMD_WIDTH));
        last_c = (beat_q == BEAT_W'(BEATS - 1));
        addr_c = base_q + (ADDR_W'(beat_q) * ADDR_W'(SIMD_WIDTH));
    end

    // Counters advance on every accepted beat; row and beat wrap after the final beat.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            beat_q <= '0;
        end else if (clr_i) begin
            base_q <= base_i;
            row_q  <= '0;
            col_q  <= '0;
            beat_q <= '0;
        end else if (inc_i) begin
            if (eol_c) begin
                col_q <= '0;
                row_q <= last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(SIMD_WIDTH);
            end
            beat_q <= last_c ? '0 : beat_q + BEAT_W'(1);
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/simd_frame_writer.sv
// Sink of the SIMD pixel stream: each accepted beat becomes one word written to
// the frame buffer over a req/gnt port, with row/column tracking, end-of-line
// framing check and a held done flag after a full frame.
// Ports: clk, rst_ni; start_i/base_addr_i arm a frame; s_valid_i/s_ready_o/
// s_data_i/s_eol_i pixel stream; mem_req_o/mem_gnt_i/mem_we_o/mem_addr_o/
// mem_wdata_o/mem_be_o memory port; row_o/col_o position; busy_o, done_o, err_o status.
module simd_frame_writer #(
    parameter int unsigned WIDTH      = pkg_img::IMG_WIDTH,
    parameter int unsigned HEIGHT     = pkg_img::IMG_HEIGHT,
    parameter int unsigned SIMD_WIDTH = pkg_img::SIMD_WIDTH,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [SIMD_WIDTH*8-1:0]   s_data_i,
    input  logic                      s_eol_i,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [SIMD_WIDTH*8-1:0]   mem_wdata_o,
    output logic [SIMD_WIDTH-1:0]     mem_be_o,
    output logic [$clog2(HEIGHT)-1:0] row_o,
    output logic [$clog2(WIDTH)-1:0]  col_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    import pkg_img::*;

    localparam int unsigned DATA_W = SIMD_WIDTH * 8;

    writer_state_e     state_q, state_d;
    logic              accept_c, clr_c, flush_done_c, frame_err_c;
    logic              gen_eol_c, gen_last_c;
    logic [ADDR_W-1:0] gen_addr_c;
    logic              req_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    frame_addr_gen #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .SIMD_WIDTH (SIMD_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_ni (rst_ni),
        .clr_i  (clr_c),
        .base_i (base_addr_i),
        .inc_i  (accept_c),
        .row_o  (row_o),
        .col_o  (col_o),
        .addr_c (gen_addr_c),
        .eol_c  (gen_eol_c),
        .last_c (gen_last_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state; start is only honoured from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (accept_c && gen_last_c) state_d = FLUSH;
            FLUSH:   if (req_q && mem_gnt_i) state_d = DONE;
            DONE:    if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and control strobes; ready looks through a same-cycle grant.
    always_comb begin
        s_ready_o    = (state_q == RUN) && (!req_q || mem_gnt_i);
        accept_c     = s_valid_i && s_ready_o;
        clr_c        = start_i && ((state_q == IDLE) || (state_q == DONE));
        flush_done_c = (state_q == FLUSH) && req_q && mem_gnt_i;
        frame_err_c  = accept_c && (s_eol_i != gen_eol_c);
    end

    // One-entry request register plus frame status flags.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                req_q   <= 1'b1;
                addr_q  <= gen_addr_c;
                wdata_q <= s_data_i;
            end else if (mem_gnt_i) begin
                req_q   <= 1'b0;
            end

            if (clr_c) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (flush_done_c) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                if (frame_err_c) err_q <= 1'b1;
            end
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = 1'b1;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = '1;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_simd_frame_writer.sv
// Directed bench for simd_frame_writer at the default 64x64, 4-pixel geometry.
module tb_simd_frame_writer;

    import pkg_img::*;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        s_valid_i;
    logic        s_ready_o;
    pix_beat_t   s_data_i;
    logic        s_eol_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [5:0]  row_o;
    logic [5:0]  col_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    simd_frame_writer dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_eol_i     (s_eol_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .row_o       (row_o),
        .col_o       (col_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observations gathered by drive_frame
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_cyc, first_grant_cyc, last_grant_cyc, stall_breaks;
    int          err_first_cyc, err_drop, err_acc_cyc, first_bad;
    logic        done_at1, err_end;
    logic [5:0]  row21, col21;

    // Beat n of a frame: mode 0 = {4{n[7:0]}}, mode 1 = thresholded checkerboard of 200/50
    function automatic logic [31:0] beat_word(input int n, input int mode);
        logic [31:0] nv;
        logic [31:0] w;
        int          row, col;
        logic [7:0]  raw;
        nv = 32'(n);
        w  = '0;
        if (mode == 0) begin
            w = {4{nv[7:0]}};
        end else begin
            row = n / int'(BEATS_PER_ROW);
            for (int k = 0; k < 4; k++) begin
                col = (n % int'(BEATS_PER_ROW)) * 4 + k;
                raw = (((row + col) % 2) == 0) ? 8'd200 : 8'd50;
                w[8*k +: 8] = (raw >= THRESHOLD) ? 8'hFF : 8'h00;
            end
        end
        return w;
    endfunction

    // Number of recorded writes that differ from the in-order expected image
    function automatic int count_bad(input logic [31:0] base, input int mode);
        int bad;
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (obs_addr[i] !== base + 32'(i) * 32'd4 || obs_data[i] !== beat_word(i, mode)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return bad;
    endfunction

    // Runs one frame from a start pulse at cycle 0; called at posedge+1
    task automatic drive_frame(input logic [31:0] base, input int gnt_pct, input int valid_pct,
                               input int err_beat, input int mode, input int rogue_cyc,
                               input int budget);
        int          n;
        logic        prev_stall;
        logic [31:0] prev_a, prev_d;
        obs_addr.delete();
        obs_data.delete();
        done_cyc = -1; first_grant_cyc = -1; last_grant_cyc = -1; stall_breaks = 0;
        err_first_cyc = -1; err_drop = 0; err_acc_cyc = -1;
        done_at1 = 1'bx; row21 = 'x; col21 = 'x;
        n = 0; prev_stall = 1'b0; prev_a = '0; prev_d = '0;
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            start_i     = (cyc == 0) || (cyc == rogue_cyc);
            base_addr_i = (cyc == 0) ? base : 32'hDEAD_0000;
            mem_gnt_i   = (gnt_pct >= 100) || (int'($urandom_range(0, 99)) < gnt_pct);
            s_valid_i   = (n < int'(BEATS_PER_FRAME)) &&
                          ((valid_pct >= 100) || (int'($urandom_range(0, 99)) < valid_pct));
            s_data_i    = beat_word(n, mode);
            s_eol_i     = ((n % int'(BEATS_PER_ROW)) == int'(BEATS_PER_ROW) - 1) ^ (n == err_beat);
            #1;
            if (mem_req_o && mem_gnt_i) begin
                obs_addr.push_back(mem_addr_o);
                obs_data.push_back(mem_wdata_o);
                if (first_grant_cyc < 0) first_grant_cyc = cyc;
                last_grant_cyc = cyc;
            end
            if (prev_stall && (!mem_req_o || mem_addr_o !== prev_a || mem_wdata_o !== prev_d))
                stall_breaks++;
            prev_stall = mem_req_o && !mem_gnt_i;
            prev_a     = mem_addr_o;
            prev_d     = mem_wdata_o;
            if (cyc == 1) done_at1 = done_o;
            if (cyc == 21) begin
                row21 = row_o;
                col21 = col_o;
            end
            if (cyc >= 1) begin
                if (err_o && err_first_cyc < 0) err_first_cyc = cyc;
                if (!err_o && err_first_cyc >= 0) err_drop++;
                if (done_o && done_cyc < 0) done_cyc = cyc;
            end
            if (s_valid_i && s_ready_o) begin
                if (n == err_beat) err_acc_cyc = cyc;
                n++;
            end
            @(posedge clk);
            #1;
        end
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        mem_gnt_i = 1'b0;
        err_end   = err_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; s_valid_i = 1'b0;
        s_data_i = '0; s_eol_i = 1'b0; mem_gnt_i = 1'b0;
        #12;
        checks++;
        if ({s_ready_o, mem_req_o, busy_o, done_o, err_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {s_ready_o, mem_req_o, busy_o, done_o, err_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, row_o, col_o} !== 76'h0) begin
            failures++;
            $display("FAIL reset_regs addr=%h data=%h row=%0d col=%0d want all 0",
                     mem_addr_o, mem_wdata_o, row_o, col_o);
        end
        checks++;
        if (mem_we_o !== 1'b1 || mem_be_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_consts we=%b be=%h want we=1 be=f", mem_we_o, mem_be_o);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int bad;
        drive_frame(32'h1000, 100, 100, -1, 0, -1, 3000);
        bad = count_bad(32'h1000, 0);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0) begin
            failures++;
            $display("FAIL full_writes count=%0d bad=%0d first_bad=%0d want count=1024 bad=0",
                     obs_addr.size(), bad, first_bad);
        end
        checks++;
        if (obs_addr.size() > 0 && obs_addr[obs_addr.size()-1] !== 32'h1FFC) begin
            failures++;
            $display("FAIL full_last_addr got=%h want=00001ffc", obs_addr[obs_addr.size()-1]);
        end
        checks++;
        if (first_grant_cyc !== 2 || last_grant_cyc !== 1025) begin
            failures++;
            $display("FAIL full_grant_timing first=%0d last=%0d want first=2 last=1025",
                     first_grant_cyc, last_grant_cyc);
        end
        checks++;
        if (done_cyc !== 1026) begin
            failures++;
            $display("FAIL full_done_cycle got=%0d want=1026", done_cyc);
        end
        checks++;
        if (row21 !== 6'd1 || col21 !== 6'd16) begin
            failures++;
            $display("FAIL full_row_col row=%0d col=%0d want row=1 col=16", row21, col21);
        end
        checks++;
        if (err_first_cyc !== -1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL full_err_busy err_cyc=%0d busy=%b want err_cyc=-1 busy=0",
                     err_first_cyc, busy_o);
        end
    endtask

    task automatic test_framing_error();
        int bad;
        drive_frame(32'h1000, 100, 100, 5, 0, -1, 3000);
        checks++;
        if (err_acc_cyc !== 6 || err_first_cyc !== 7) begin
            failures++;
            $display("FAIL eol_err_timing acc_cyc=%0d err_cyc=%0d want acc=6 err=7",
                     err_acc_cyc, err_first_cyc);
        end
        checks++;
        if (err_drop !== 0 || err_end !== 1'b1) begin
            failures++;
            $display("FAIL eol_err_sticky drops=%0d end=%b want drops=0 end=1", err_drop, err_end);
        end
        bad = count_bad(32'h1000, 0);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0 || done_cyc !== 1026) begin
            failures++;
            $display("FAIL eol_err_frame count=%0d bad=%0d done_cyc=%0d want 1024/0/1026",
                     obs_addr.size(), bad, done_cyc);
        end
    endtask

    task automatic test_restart();
        int bad;
        drive_frame(32'h8000, 100, 100, -1, 0, 50, 3000);
        checks++;
        if (done_at1 !== 1'b0 || err_first_cyc !== -1) begin
            failures++;
            $display("FAIL restart_clear done_at1=%b err_cyc=%0d want done=0 err_cyc=-1",
                     done_at1, err_first_cyc);
        end
        checks++;
        if (obs_addr.size() == 0 || obs_addr[0] !== 32'h8000) begin
            failures++;
            $display("FAIL restart_first_addr got=%h want=00008000",
                     (obs_addr.size() > 0) ? obs_addr[0] : 32'hx);
        end
        bad = count_bad(32'h8000, 0);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0 || done_cyc !== 1026) begin
            failures++;
            $display("FAIL restart_frame count=%0d bad=%0d done_cyc=%0d want 1024/0/1026",
                     obs_addr.size(), bad, done_cyc);
        end
    endtask

    task automatic test_random_stalls();
        int bad;
        drive_frame(32'h0003_0000, 30, 60, -1, 0, -1, 20000);
        bad = count_bad(32'h0003_0000, 0);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0) begin
            failures++;
            $display("FAIL stall_writes count=%0d bad=%0d first_bad=%0d want count=1024 bad=0",
                     obs_addr.size(), bad, first_bad);
        end
        checks++;
        if (stall_breaks !== 0) begin
            failures++;
            $display("FAIL stall_hold breaks=%0d want=0", stall_breaks);
        end
        checks++;
        if (done_cyc < 0 || done_cyc !== last_grant_cyc + 1) begin
            failures++;
            $display("FAIL stall_done done_cyc=%0d last_grant=%0d want done=last_grant+1",
                     done_cyc, last_grant_cyc);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   n;
        logic found;
        int   bad;
        n = 0;
        found = 1'b0;
        mem_gnt_i   = 1'b1;
        s_valid_i   = 1'b1;
        base_addr_i = 32'h4000;
        for (int c = 0; c < 400 && !found; c++) begin
            start_i  = (c == 0);
            s_data_i = beat_word(n, 0);
            s_eol_i  = ((n % int'(BEATS_PER_ROW)) == int'(BEATS_PER_ROW) - 1);
            #1;
            if (row_o == 6'd10) begin
                found = 1'b1;
            end else begin
                if (s_valid_i && s_ready_o) n++;
                @(posedge clk);
                #1;
            end
        end
        start_i   = 1'b0;
        mem_gnt_i = 1'b0;
        #1;
        checks++;
        if (found !== 1'b1 || mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup row10=%b req=%b want both 1", found, mem_req_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async req=%b busy=%b ready=%b want 0/0/0",
                     mem_req_o, busy_o, s_ready_o);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (s_ready_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle ready=%b busy=%b req=%b done=%b want all 0",
                     s_ready_o, busy_o, mem_req_o, done_o);
        end
        s_valid_i = 1'b0;
        drive_frame(32'h2000, 100, 100, -1, 0, -1, 3000);
        bad = count_bad(32'h2000, 0);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0 || done_cyc !== 1026) begin
            failures++;
            $display("FAIL midrst_new_frame count=%0d bad=%0d done_cyc=%0d want 1024/0/1026",
                     obs_addr.size(), bad, done_cyc);
        end
    endtask

    task automatic test_threshold();
        int bad;
        drive_frame(32'h0, 100, 100, -1, 1, -1, 3000);
        checks++;
        if (obs_data.size() < 17 || obs_data[0] !== 32'h00FF00FF || obs_data[16] !== 32'hFF00FF00) begin
            failures++;
            $display("FAIL thresh_words beat0=%h beat16=%h want 00ff00ff ff00ff00",
                     (obs_data.size() > 0) ? obs_data[0] : 32'hx,
                     (obs_data.size() > 16) ? obs_data[16] : 32'hx);
        end
        bad = count_bad(32'h0, 1);
        checks++;
        if (obs_addr.size() !== 1024 || bad !== 0) begin
            failures++;
            $display("FAIL thresh_frame count=%0d bad=%0d want count=1024 bad=0",
                     obs_addr.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_framing_error();
        test_restart();
        test_random_stalls();
        test_reset_mid_frame();
        test_threshold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
